decode_issue: RTL and testbench
===============================

Name: decode_issue

Overview:
- Decode/issue stage driving the execute stage's operand inputs.
- Accepts raw RV64IM instructions from fetch and decodes them into op, rd, operand values and sign-extended immediate.
- Reads the register file through two combinational read ports.
- Tracks in-flight destination registers with a scoreboard.
- Presents one registered ID/EX bundle per instruction under a valid/ready handshake.

Parameters:
- XLEN, 64, datapath width of operands, immediate and pc.
- NREGS, 32, architectural register count; scoreboard width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage accepts instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- rf_raddr1, rf_raddr2  out  5 each  register-file read addresses (= instr[19:15], instr[24:20]).
- rf_rdata1, rf_rdata2  in  XLEN each  combinational read data.
- wb_valid  in  1  execute retired a write.
- wb_rd  in  5  retired destination.
- wb_data  in  XLEN  retired value (used only with bypass).
- flush  in  1  discard held and incoming instruction.
- ex_valid  out  1  ID/EX bundle valid.
- ex_ready  in  1  execute consumes bundle.
- ex_op  out  6  op_t code.
- ex_rd  out  5  destination index.
- ex_rs1, ex_rs2  out  XLEN  operand values.
- ex_imm  out  XLEN  sign-extended immediate (U-type already shifted by 12).
- ex_pc  out  XLEN  pc of bundle.
- ex_illegal  out  1  undecodable instruction.
- busy_regs  out  NREGS  scoreboard, bit i = write to xi pending.

Behaviour:
- Reset (async, reset=0): ex_valid=0, ex_op=OP_NOP, ex_rd/ex_rs1/ex_rs2/ex_imm/ex_pc=0, ex_illegal=0, busy_regs=0. in_ready is combinational; it is 0 while in reset. A bundle in flight during reset is lost.
- Decode:
  - Classes: OP, OP-IMM, OP-32, OP-IMM-32, LUI, AUIPC, JAL, JALR, M-extension (funct7=0000001).
  - Anything else decodes to OP_NOP with ex_illegal=1, rd forced to 0.
- Operand use: rs1 is used by all except LUI/AUIPC/JAL. rs2 is used by R-type only.
- Register x0: reads as 0 regardless of rf_rdata; never marked busy.
- hazard = (rs1 used and busy[rs1]) or (rs2 used and busy[rs2]) or (rd!=0 and busy[rd]), where WAW stalls.
- in_ready = reset and !hazard and (!ex_valid or ex_ready) and !flush. When in_valid=0 the hazard term is ignored.
- Accept (in_valid & in_ready): capture bundle next edge, ex_valid=1; set busy[rd] if rd!=0.
- Hold: ex_valid & !ex_ready, so every ex_* output remains stable.
- Drain: ex_ready & ex_valid with no accept → ex_valid=0 next edge.
- Latency: accept to ex_valid is 1 cycle. Throughput is 1/cycle when hazard-free.
- Writeback: wb_valid clears busy[wb_rd] next edge. wb_rd=0 has no effect.
- Same-cycle set and clear of the same index: set wins.
- Same-cycle writeback whose wb_rd matches a source of the waiting instruction still stalls that cycle (no bypass build). The register file is written at the same edge; issue proceeds the following cycle.
- flush:
  - ex_valid=0 next edge.
  - The incoming instruction is not accepted.
  - The busy bit set for the flushed bundle's rd is cleared.
  - Other busy bits are unchanged.
- Shift immediates: imm[5:0] for RV64 forms, imm[4:0] for *W forms; the srai/sraiw funct6/funct7 bit is excluded from ex_imm.

Optional Feature:
- Macro: DECODE_ISSUE_WB_BYPASS_EN.
- Defined: a source matching wb_rd with wb_valid (rd!=0) is treated as not busy. The operand is taken from wb_data instead of rf_rdata. Issue happens in the same cycle as writeback.
- Undefined: wb_data is unused and the behaviour is as above.

Decomposition:
- Package rv_decode_pkg: op_t enum (OP_NOP, OP_ADD … OP_MULHU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR), major opcode localparams, funct3/funct7 constants, XLEN default.
- Sub-module rv_instr_decoder (purely combinational): instr → op, rd, rs1/rs2 indices and use flags, imm, illegal.
- decode_issue owns the scoreboard, handshake and pipeline register.

Test Plan:
- reset=0 mid-bundle → ex_valid=0 and busy_regs=0 immediately; after release, addi x1,x0,5 (0x00500093) → next cycle ex_op=OP_ADDI, ex_rd=1, ex_imm=5, busy_regs=0x2.
- addi x1 then add x2,x1,x1 (0x00108133) → in_ready=0 until wb_valid with wb_rd=1. Issue occurs the cycle after writeback (one cycle earlier under bypass, ex_rs1=ex_rs2=wb_data=5).
- lui x5,0x12345 (0x123452B7) → ex_op=OP_LUI, ex_imm=0x0000000012345000. sraiw x3,x3,31 → ex_imm=31.
- Instruction 0x00000000 → ex_illegal=1, ex_rd=0, busy_regs unchanged.
- ex_ready=0 for 5 cycles with ex_valid=1 → all ex_* stable, in_ready=0. ex_ready=1 → next bundle issues the following cycle.
- Issue mul x7 then flush → ex_valid=0 next edge and busy_regs[7]=0; concurrent in_valid is not accepted.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV64IM decode types: op codes, opcode/funct constants and the decoded-instruction payload.
package rv_decode_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned OP_W      = 6;

  typedef enum logic [OP_W-1:0] {
    OP_NOP,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
    OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
    OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
  } op_t;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef struct packed {
    op_t                 op;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic                use_rs1;
    logic                use_rs2;
    logic                illegal;
    logic [XLEN_DEF-1:0] imm;
  } dec_t;

endpackage

// File: rtl/rv_instr_decoder.sv
// Purely combinational RV64IM decoder: raw word to op, register indices, use flags and immediate.
module rv_instr_decoder
  import rv_decode_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]          opc;
  logic [2:0]          f3;
  logic [6:0]          f7;
  logic                legal;
  logic [XLEN_DEF-1:0] imm_i;
  logic [XLEN_DEF-1:0] imm_u;
  logic [XLEN_DEF-1:0] imm_j;
  logic [XLEN_DEF-1:0] shamt6;
  logic [XLEN_DEF-1:0] shamt5;

  assign opc    = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{(XLEN_DEF-12){instr[31]}}, instr[31:20]};
  assign imm_u  = {{(XLEN_DEF-32){instr[31]}}, instr[31:12], 12'b0};
  assign imm_j  = {{(XLEN_DEF-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  // Shift amounts exclude the funct6/funct7 selector bits that distinguish arithmetic shifts.
  assign shamt6 = XLEN_DEF'(instr[25:20]);
  assign shamt5 = XLEN_DEF'(instr[24:20]);

  always_comb begin
    dec     = '0;
    dec.rd  = instr[11:7];
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    legal   = 1'b1;
    case (opc)
      OPC_OP: begin
        dec.use_rs1 = 1'b1;
        dec.use_rs2 = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD:  dec.op = OP_ADD;
            F3_SLL:  dec.op = OP_SLL;
            F3_SLT:  dec.op = OP_SLT;
            F3_SLTU: dec.op = OP_SLTU;
            F3_XOR:  dec.op = OP_XOR;
            F3_SR:   dec.op = OP_SRL;
            F3_OR:   dec.op = OP_OR;
            default: dec.op = OP_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          dec.op = OP_SUB;
        end else if (f7 == F7_ALT && f3 == F3_SR) begin
          dec.op = OP_SRA;
        end else if (f7 == F7_MULDIV) begin
          case (f3)
            F3_MUL:    dec.op = OP_MUL;
            F3_MULH:   dec.op = OP_MULH;
            F3_MULHSU: dec.op = OP_MULHSU;
            F3_MULHU:  dec.op = OP_MULHU;
            F3_DIV:    dec.op = OP_DIV;
            F3_DIVU:   dec.op = OP_DIVU;
            F3_REM:    dec.op = OP_REM;
            default:   dec.op = OP_REMU;
          endcase
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_32: begin
        dec.use_rs1 = 1'b1;
        dec.use_rs2 = 1'b1;
        if (f7 == F7_BASE && f3 == F3_ADD)          dec.op = OP_ADDW;
        else if (f7 == F7_BASE && f3 == F3_SLL)     dec.op = OP_SLLW;
        else if (f7 == F7_BASE && f3 == F3_SR)      dec.op = OP_SRLW;
        else if (f7 == F7_ALT && f3 == F3_ADD)      dec.op = OP_SUBW;
        else if (f7 == F7_ALT && f3 == F3_SR)       dec.op = OP_SRAW;
        else if (f7 == F7_MULDIV && f3 == F3_MUL)   dec.op = OP_MULW;
        else if (f7 == F7_MULDIV && f3 == F3_DIV)   dec.op = OP_DIVW;
        else if (f7 == F7_MULDIV && f3 == F3_DIVU)  dec.op = OP_DIVUW;
        else if (f7 == F7_MULDIV && f3 == F3_REM)   dec.op = OP_REMW;
        else if (f7 == F7_MULDIV && f3 == F3_REMU)  dec.op = OP_REMUW;
        else                                        legal  = 1'b0;
      end
      OPC_OP_IMM: begin
        dec.use_rs1 = 1'b1;
        dec.imm     = imm_i;
        case (f3)
          F3_ADD:  dec.op = OP_ADDI;
          F3_SLT:  dec.op = OP_SLTI;
          F3_SLTU: dec.op = OP_SLTIU;
          F3_XOR:  dec.op = OP_XORI;
          F3_OR:   dec.op = OP_ORI;
          F3_AND:  dec.op = OP_ANDI;
          F3_SLL: begin
            dec.op  = OP_SLLI;
            dec.imm = shamt6;
            legal   = (instr[31:26] == 6'b000000);
          end
          default: begin
            dec.imm = shamt6;
            if (instr[31:26] == 6'b000000)      dec.op = OP_SRLI;
            else if (instr[31:26] == 6'b010000) dec.op = OP_SRAI;
            else                                legal  = 1'b0;
          end
        endcase
      end
      OPC_OP_IMM_32: begin
        dec.use_rs1 = 1'b1;
        dec.imm     = shamt5;
        if (f3 == F3_ADD) begin
          dec.op  = OP_ADDIW;
          dec.imm = imm_i;
        end else if (f3 == F3_SLL && f7 == F7_BASE) dec.op = OP_SLLIW;
        else if (f3 == F3_SR && f7 == F7_BASE)      dec.op = OP_SRLIW;
        else if (f3 == F3_SR && f7 == F7_ALT)       dec.op = OP_SRAIW;
        else                                        legal  = 1'b0;
      end
      OPC_LUI: begin
        dec.op  = OP_LUI;
        dec.imm = imm_u;
      end
      OPC_AUIPC: begin
        dec.op  = OP_AUIPC;
        dec.imm = imm_u;
      end
      OPC_JAL: begin
        dec.op  = OP_JAL;
        dec.imm = imm_j;
      end
      OPC_JALR: begin
        dec.op      = OP_JALR;
        dec.use_rs1 = 1'b1;
        dec.imm     = imm_i;
        legal       = (f3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.op      = OP_NOP;
      dec.rd      = '0;
      dec.use_rs1 = 1'b0;
      dec.use_rs2 = 1'b0;
      dec.imm     = '0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: scoreboard, fetch/execute handshake and the ID/EX pipeline register.
// Optional macro DECODE_ISSUE_WB_BYPASS_EN forwards a same-cycle writeback into the issuing operands.
module decode_issue
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output op_t               ex_op,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rs1,
  output logic [XLEN-1:0]   ex_rs2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic              ex_illegal,
  output logic [NREGS-1:0]  busy_regs
);

  dec_t             dec;
  logic             src1_busy;
  logic             src2_busy;
  logic [XLEN-1:0]  op1;
  logic [XLEN-1:0]  op2;
  logic             hazard;
  logic             accept;
  logic [NREGS-1:0] busy_nxt;

  rv_instr_decoder u_decoder (
    .instr (in_instr),
    .dec   (dec)
  );

  assign rf_raddr1 = in_instr[19:15];
  assign rf_raddr2 = in_instr[24:20];

  // Operand selection and hazard detection; x0 is never busy and always reads zero.
  always_comb begin
    src1_busy = busy_regs[dec.rs1];
    src2_busy = busy_regs[dec.rs2];
    op1       = rf_rdata1;
    op2       = rf_rdata2;
`ifdef DECODE_ISSUE_WB_BYPASS_EN
    if (wb_valid && wb_rd != '0 && wb_rd == dec.rs1) begin
      src1_busy = 1'b0;
      op1       = wb_data;
    end
    if (wb_valid && wb_rd != '0 && wb_rd == dec.rs2) begin
      src2_busy = 1'b0;
      op2       = wb_data;
    end
`endif
    if (dec.rs1 == '0 || !dec.use_rs1) op1 = '0;
    if (dec.rs2 == '0 || !dec.use_rs2) op2 = '0;
    hazard = in_valid && ((dec.use_rs1 && src1_busy) || (dec.use_rs2 && src2_busy) ||
                          (dec.rd != '0 && busy_regs[dec.rd]));
  end

`ifndef DECODE_ISSUE_WB_BYPASS_EN
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  assign in_ready = reset && !hazard && (!ex_valid || ex_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Set after clears so a same-cycle issue to a retiring register keeps it busy.
  always_comb begin
    busy_nxt = busy_regs;
    if (wb_valid && wb_rd != '0) busy_nxt[wb_rd] = 1'b0;
    if (flush && ex_valid && ex_rd != '0) busy_nxt[ex_rd] = 1'b0;
    if (accept && dec.rd != '0) busy_nxt[dec.rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid   <= 1'b0;
      ex_op      <= OP_NOP;
      ex_rd      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_imm     <= '0;
      ex_pc      <= '0;
      ex_illegal <= 1'b0;
      busy_regs  <= '0;
    end else begin
      busy_regs <= busy_nxt;
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (accept) begin
        ex_valid   <= 1'b1;
        ex_op      <= dec.op;
        ex_rd      <= dec.rd;
        ex_rs1     <= op1;
        ex_rs2     <= op2;
        ex_imm     <= XLEN'(dec.imm);
        ex_pc      <= in_pc;
        ex_illegal <= dec.illegal;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: decode vector table plus handshake, scoreboard and flush sequences.
module tb_decode_issue;
  import rv_decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [63:0] rf_rdata1, rf_rdata2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  op_t         ex_op;
  logic [4:0]  ex_rd;
  logic [63:0] ex_rs1, ex_rs2, ex_imm, ex_pc;
  logic        ex_illegal;
  logic [31:0] busy_regs;

  logic [63:0] rf [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  always #5 clk = ~clk;

  decode_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_illegal(ex_illegal), .busy_regs(busy_regs)
  );

  typedef struct {
    logic [31:0] instr;
    op_t         op;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] busy;
    logic        ill;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle; the bench register file absorbs the writeback presented at that edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (wb_valid && wb_rd != 5'd0) rf[wb_rd] = wb_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 64'(r) * 64'h1111;
    rf[0] = 64'hDEAD_BEEF_DEAD_BEEF;

    vecs[0]  = '{32'h00500093, OP_ADDI,  5'd1,  64'd5,                  64'd0,      64'd0,      64'h2,   1'b0};
    vecs[1]  = '{32'h002081B3, OP_ADD,   5'd3,  64'd0,                  64'h1111,   64'h2222,   64'h8,   1'b0};
    vecs[2]  = '{32'h123452B7, OP_LUI,   5'd5,  64'h0000_0000_1234_5000, 64'd0,     64'd0,      64'h20,  1'b0};
    vecs[3]  = '{32'h80000337, OP_LUI,   5'd6,  64'hFFFF_FFFF_8000_0000, 64'd0,     64'd0,      64'h40,  1'b0};
    vecs[4]  = '{32'h41F1D19B, OP_SRAIW, 5'd3,  64'd31,                 64'h3333,   64'd0,      64'h8,   1'b0};
    vecs[5]  = '{32'h43F25213, OP_SRAI,  5'd4,  64'd63,                 64'h4444,   64'd0,      64'h10,  1'b0};
    vecs[6]  = '{32'hFFF08113, OP_ADDI,  5'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1111,  64'd0,      64'h4,   1'b0};
    vecs[7]  = '{32'h008000EF, OP_JAL,   5'd1,  64'd8,                  64'd0,      64'd0,      64'h2,   1'b0};
    vecs[8]  = '{32'h00008067, OP_JALR,  5'd0,  64'd0,                  64'h1111,   64'd0,      64'h0,   1'b0};
    vecs[9]  = '{32'h026283BB, OP_MULW,  5'd7,  64'd0,                  64'h5555,   64'h6666,   64'h80,  1'b0};
    vecs[10] = '{32'h00000000, OP_NOP,   5'd0,  64'd0,                  64'd0,      64'd0,      64'h0,   1'b1};
    vecs[11] = '{32'h00001517, OP_AUIPC, 5'd10, 64'h1000,               64'd0,      64'd0,      64'h400, 1'b0};
    vecs[12] = '{32'h20000033, OP_NOP,   5'd0,  64'd0,                  64'd0,      64'd0,      64'h0,   1'b1};
    vecs[13] = '{32'h023150B3, OP_DIVU,  5'd1,  64'd0,                  64'h2222,   64'h3333,   64'h2,   1'b0};

    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;

    #3;
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset ex_valid", 64'(ex_valid), 64'd0);
    chk("reset ex_op", 64'(ex_op), 64'(OP_NOP));
    chk("reset busy", 64'(busy_regs), 64'd0);
    chk("reset ex_imm", ex_imm, 64'd0);
    step(); step();
    reset = 1'b1;

    // Decode table: issue, check bundle, then retire rd to leave the scoreboard empty.
    for (int i = 0; i < 14; i++) begin
      in_instr = vecs[i].instr;
      in_pc    = 64'h8000_0000 + 64'(i * 4);
      in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d ex_valid", i), 64'(ex_valid), 64'd1);
      chk($sformatf("v%0d ex_op", i), 64'(ex_op), 64'(vecs[i].op));
      chk($sformatf("v%0d ex_rd", i), 64'(ex_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d ex_imm", i), ex_imm, vecs[i].imm);
      chk($sformatf("v%0d ex_rs1", i), ex_rs1, vecs[i].rs1);
      chk($sformatf("v%0d ex_rs2", i), ex_rs2, vecs[i].rs2);
      chk($sformatf("v%0d ex_pc", i), ex_pc, 64'h8000_0000 + 64'(i * 4));
      chk($sformatf("v%0d ex_illegal", i), 64'(ex_illegal), 64'(vecs[i].ill));
      chk($sformatf("v%0d busy", i), 64'(busy_regs), vecs[i].busy);
      wb_valid = 1'b1; wb_rd = vecs[i].rd; wb_data = rf[vecs[i].rd];
      step();
      wb_valid = 1'b0;
      chk($sformatf("v%0d drain ex_valid", i), 64'(ex_valid), 64'd0);
      chk($sformatf("v%0d wb busy", i), 64'(busy_regs), 64'd0);
    end

    // Asynchronous reset while a bundle is held.
    ex_ready = 1'b0;
    in_instr = 32'h00500093; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pre-reset ex_valid", 64'(ex_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("midreset ex_valid", 64'(ex_valid), 64'd0);
    chk("midreset busy", 64'(busy_regs), 64'd0);
    chk("midreset in_ready", 64'(in_ready), 64'd0);
    step();
    reset = 1'b1;
    ex_ready = 1'b1;
    in_instr = 32'h00500093; in_pc = 64'h100; in_valid = 1'b1;
    step();
    chk("post-reset ex_op", 64'(ex_op), 64'(OP_ADDI));
    chk("post-reset ex_rd", 64'(ex_rd), 64'd1);
    chk("post-reset ex_imm", ex_imm, 64'd5);
    chk("post-reset busy", 64'(busy_regs), 64'h2);

    // RAW on x1: stall until writeback of x1.
    in_instr = 32'h00108133; in_pc = 64'h104;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("raw stall %0d in_ready", k), 64'(in_ready), 64'd0);
      step();
    end
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 64'd5;
    #1;
`ifdef DECODE_ISSUE_WB_BYPASS_EN
    chk("raw wb-cycle in_ready", 64'(in_ready), 64'd1);
    step();
    wb_valid = 1'b0;
`else
    chk("raw wb-cycle in_ready", 64'(in_ready), 64'd0);
    step();
    wb_valid = 1'b0;
    #1;
    chk("raw post-wb in_ready", 64'(in_ready), 64'd1);
    step();
`endif
    in_valid = 1'b0;
    ex_ready = 1'b0;
    chk("raw ex_op", 64'(ex_op), 64'(OP_ADD));
    chk("raw ex_rd", 64'(ex_rd), 64'd2);
    chk("raw ex_rs1", ex_rs1, 64'd5);
    chk("raw ex_rs2", ex_rs2, 64'd5);
    chk("raw busy", 64'(busy_regs), 64'h4);

    // Backpressure: bundle held stable for 5 cycles.
    in_instr = 32'h00100513; in_pc = 64'h108; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("hold %0d in_ready", k), 64'(in_ready), 64'd0);
      chk($sformatf("hold %0d ex_valid", k), 64'(ex_valid), 64'd1);
      chk($sformatf("hold %0d ex_op", k), 64'(ex_op), 64'(OP_ADD));
      chk($sformatf("hold %0d ex_rd", k), 64'(ex_rd), 64'd2);
      chk($sformatf("hold %0d ex_rs1", k), ex_rs1, 64'd5);
      chk($sformatf("hold %0d ex_pc", k), ex_pc, 64'h104);
      step();
    end
    ex_ready = 1'b1;
    #1;
    chk("release in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("release ex_rd", 64'(ex_rd), 64'd10);
    chk("release ex_op", 64'(ex_op), 64'(OP_ADDI));
    chk("release ex_imm", ex_imm, 64'd1);
    chk("release busy", 64'(busy_regs), 64'h404);

    // Flush a held mul x7; concurrent fetch must not be accepted.
    in_instr = 32'h026283B3; in_pc = 64'h10C; in_valid = 1'b1;
    step();
    chk("mul ex_op", 64'(ex_op), 64'(OP_MUL));
    chk("mul ex_rs1", ex_rs1, 64'h5555);
    chk("mul busy", 64'(busy_regs), 64'h484);
    ex_ready = 1'b0;
    in_instr = 32'h00100593; in_pc = 64'h110; flush = 1'b1;
    #1;
    chk("flush in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush ex_valid", 64'(ex_valid), 64'd0);
    chk("flush busy", 64'(busy_regs), 64'h404);

    // Same-edge set and clear of x3: set wins; wb_rd=0 is a no-op.
    ex_ready = 1'b1;
    in_instr = 32'h00100193; in_pc = 64'h114; in_valid = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = rf[3];
    #1;
    chk("setclr in_ready", 64'(in_ready), 64'd1);
    step();
    wb_valid = 1'b0; in_valid = 1'b0;
    chk("setclr ex_rd", 64'(ex_rd), 64'd3);
    chk("setclr busy", 64'(busy_regs), 64'h40C);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'd0;
    step();
    wb_valid = 1'b0;
    chk("wb x0 busy", 64'(busy_regs), 64'h40C);
    chk("drain ex_valid", 64'(ex_valid), 64'd0);

    // Retire remaining destinations.
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = rf[2];
    step();
    wb_rd = 5'd3; wb_data = rf[3];
    step();
    wb_rd = 5'd10; wb_data = rf[10];
    step();
    wb_valid = 1'b0;
    chk("final busy", 64'(busy_regs), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
